seq_ram_arbiter: RTL and testbench

Shares the single registered read port of a sequence RAM (3-bit nucleotide codes, 1-cycle read latency, `en_dout`/`addr_dout`/`dout`) between the matrix-fill reader and the traceback engine of the Needleman-Wunsch core. It arbitrates requests, drives the RAM enable and address, tracks in-flight reads with a two-stage tag pipeline, and returns data to the correct requester with a valid pulse. One instance sits in front of each sequence RAM (A and B).

---
 rtl/seq_ram_arbiter.sv | 128 ++++++++++++
 tb/tb_seq_ram_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/seq_ram_arbiter.sv
// Read-port arbiter for one sequence RAM, shared by the matrix-fill reader and the traceback engine.
// Define SEQ_ARB_RR_EN for round-robin arbitration; otherwise traceback has fixed priority over fill.
module seq_ram_arbiter #(
  parameter int N   = 128,
  parameter int Bit = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req_fill,
  input  logic [Bit-1:0] addr_fill,
  input  logic           req_trace,
  input  logic [Bit-1:0] addr_trace,
  output logic           gnt_fill,
  output logic           gnt_trace,
  output logic           valid_fill,
  output logic           valid_trace,
  output logic [2:0]     data_fill,
  output logic [2:0]     data_trace,
  output logic           ram_en,
  output logic [Bit-1:0] ram_addr,
  input  logic [2:0]     ram_dout,
  input  logic           clr_err,
  output logic           oob_err,
  output logic           busy
);

  localparam logic [Bit:0] NLim = (Bit+1)'(N);

  logic           gnt_fill_c, gnt_trace_c, granted;
  logic [Bit-1:0] sel_addr;
  logic           sel_oob;

  logic       s1_valid_q, s1_valid_d;
  logic       s1_id_q, s1_id_d;
  logic       s1_oob_q, s1_oob_d;
  logic       valid_fill_q, valid_fill_d;
  logic       valid_trace_q, valid_trace_d;
  logic [2:0] data_fill_q, data_fill_d;
  logic [2:0] data_trace_q, data_trace_d;
  logic       oob_err_q, oob_err_d;

`ifdef SEQ_ARB_RR_EN
  logic last_trace_q, last_trace_d;
`endif

  // Grants are gated by reset so nothing reaches the RAM while the pipeline is held clear.
  always_comb begin
    gnt_fill_c  = 1'b0;
    gnt_trace_c = 1'b0;
    if (rst) begin
`ifdef SEQ_ARB_RR_EN
      if (req_fill && req_trace) begin
        if (last_trace_q) gnt_fill_c  = 1'b1;
        else              gnt_trace_c = 1'b1;
      end else begin
        gnt_fill_c  = req_fill;
        gnt_trace_c = req_trace;
      end
`else
      gnt_trace_c = req_trace;
      gnt_fill_c  = req_fill & ~req_trace;
`endif
    end
    granted  = gnt_fill_c | gnt_trace_c;
    sel_addr = gnt_trace_c ? addr_trace : addr_fill;
    sel_oob  = granted && ({1'b0, sel_addr} >= NLim);
    ram_en   = granted & ~sel_oob;
    ram_addr = ram_en ? sel_addr : '0;
  end

  always_comb begin
    s1_valid_d    = granted;
    s1_id_d       = gnt_trace_c;
    s1_oob_d      = sel_oob;
    valid_fill_d  = s1_valid_q & ~s1_id_q;
    valid_trace_d = s1_valid_q & s1_id_q;
    data_fill_d   = data_fill_q;
    data_trace_d  = data_trace_q;
    // Out-of-range reads never enabled the RAM, so return zero instead of stale dout.
    if (valid_fill_d)  data_fill_d  = s1_oob_q ? 3'b000 : ram_dout;
    if (valid_trace_d) data_trace_d = s1_oob_q ? 3'b000 : ram_dout;
    oob_err_d = oob_err_q;
    if (clr_err) oob_err_d = 1'b0;
    if (sel_oob) oob_err_d = 1'b1;
`ifdef SEQ_ARB_RR_EN
    last_trace_d = last_trace_q;
    if (granted) last_trace_d = gnt_trace_c;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q    <= 1'b0;
      s1_id_q       <= 1'b0;
      s1_oob_q      <= 1'b0;
      valid_fill_q  <= 1'b0;
      valid_trace_q <= 1'b0;
      data_fill_q   <= 3'b000;
      data_trace_q  <= 3'b000;
      oob_err_q     <= 1'b0;
`ifdef SEQ_ARB_RR_EN
      last_trace_q  <= 1'b0;
`endif
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_id_q       <= s1_id_d;
      s1_oob_q      <= s1_oob_d;
      valid_fill_q  <= valid_fill_d;
      valid_trace_q <= valid_trace_d;
      data_fill_q   <= data_fill_d;
      data_trace_q  <= data_trace_d;
      oob_err_q     <= oob_err_d;
`ifdef SEQ_ARB_RR_EN
      last_trace_q  <= last_trace_d;
`endif
    end
  end

  assign gnt_fill    = gnt_fill_c;
  assign gnt_trace   = gnt_trace_c;
  assign valid_fill  = valid_fill_q;
  assign valid_trace = valid_trace_q;
  assign data_fill   = data_fill_q;
  assign data_trace  = data_trace_q;
  assign oob_err     = oob_err_q;
  assign busy        = s1_valid_q | valid_fill_q | valid_trace_q;

endmodule

// File: tb/tb_seq_ram_arbiter.sv
// Directed bench for seq_ram_arbiter with N=5, a behavioural registered-read RAM and a scoreboard queue.
// Follows SEQ_ARB_RR_EN the same way as the design.
module tb_seq_ram_arbiter;

  localparam int N   = 5;
  localparam int Bit = 3;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           req_fill = 1'b0, req_trace = 1'b0, clr_err = 1'b0;
  logic [Bit-1:0] addr_fill = '0, addr_trace = '0;
  logic           gnt_fill, gnt_trace, valid_fill, valid_trace, ram_en, oob_err, busy;
  logic [2:0]     data_fill, data_trace, ram_dout;
  logic [Bit-1:0] ram_addr;

  logic [2:0] mem [0:7];
  logic [2:0] ram_q = 3'b000;

  typedef struct {
    int         due;
    bit         id;
    logic [2:0] data;
  } exp_t;

  exp_t       sb[$];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  logic [2:0] exp_data_fill = 3'b000, exp_data_trace = 3'b000;
  logic       exp_oob = 1'b0, g1 = 1'b0, g2 = 1'b0, last_trace = 1'b0;

  always #5 clk = ~clk;

  // Registered-read sequence RAM: one cycle from en/addr to dout.
  always @(posedge clk) if (ram_en) ram_q <= mem[ram_addr];
  assign ram_dout = ram_q;

  seq_ram_arbiter #(.N(N), .Bit(Bit)) dut (
    .clk(clk), .rst(rst),
    .req_fill(req_fill), .addr_fill(addr_fill),
    .req_trace(req_trace), .addr_trace(addr_trace),
    .gnt_fill(gnt_fill), .gnt_trace(gnt_trace),
    .valid_fill(valid_fill), .valid_trace(valid_trace),
    .data_fill(data_fill), .data_trace(data_trace),
    .ram_en(ram_en), .ram_addr(ram_addr), .ram_dout(ram_dout),
    .clr_err(clr_err), .oob_err(oob_err), .busy(busy)
  );

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input logic rf, input logic [2:0] af, input logic rt,
                               input logic [2:0] at, input logic clr);
    rst        = 1'b1;
    req_fill   = rf;
    addr_fill  = af;
    req_trace  = rt;
    addr_trace = at;
    clr_err    = clr;
  endtask

  // One clock cycle: drive after the edge, predict and compare at the falling edge.
  task automatic runCycle(input logic rf, input logic [2:0] af, input logic rt,
                          input logic [2:0] at, input logic clr);
    logic       eg_f, eg_t, egr, eoob, evf, evt;
    logic [2:0] eaddr;
    exp_t       head;
    @(posedge clk);
    #1;
    applyStimulus(rf, af, rt, at, clr);
    cyc++;
    @(negedge clk);
    eg_f = 1'b0;
    eg_t = 1'b0;
    if (rf && rt) begin
`ifdef SEQ_ARB_RR_EN
      if (last_trace) eg_f = 1'b1;
      else            eg_t = 1'b1;
`else
      eg_t = 1'b1;
`endif
    end else begin
      eg_f = rf;
      eg_t = rt;
    end
    egr   = eg_f | eg_t;
    eaddr = eg_t ? at : af;
    eoob  = egr && (int'(eaddr) >= N);
    evf   = 1'b0;
    evt   = 1'b0;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      head = sb.pop_front();
      if (head.id) begin evt = 1'b1; exp_data_trace = head.data; end
      else         begin evf = 1'b1; exp_data_fill  = head.data; end
    end
    checkOutput("gnt_fill",    8'(gnt_fill),    8'(eg_f));
    checkOutput("gnt_trace",   8'(gnt_trace),   8'(eg_t));
    checkOutput("ram_en",      8'(ram_en),      8'(egr & ~eoob));
    checkOutput("ram_addr",    8'(ram_addr),    (egr && !eoob) ? 8'(eaddr) : 8'h00);
    checkOutput("valid_fill",  8'(valid_fill),  8'(evf));
    checkOutput("valid_trace", 8'(valid_trace), 8'(evt));
    checkOutput("data_fill",   8'(data_fill),   8'(exp_data_fill));
    checkOutput("data_trace",  8'(data_trace),  8'(exp_data_trace));
    checkOutput("oob_err",     8'(oob_err),     8'(exp_oob));
    checkOutput("busy",        8'(busy),        8'(g1 | g2));
    if (egr) sb.push_back('{cyc + 2, eg_t, eoob ? 3'b000 : mem[eaddr]});
    g2 = g1;
    g1 = egr;
    if (eoob)     exp_oob = 1'b1;
    else if (clr) exp_oob = 1'b0;
    if (egr) last_trace = eg_t;
  endtask

  // Pull reset low for one cycle with a request pending; the next runCycle releases it.
  task automatic doReset();
    @(posedge clk);
    #1;
    rst        = 1'b0;
    req_fill   = 1'b1;
    addr_fill  = 3'd2;
    req_trace  = 1'b1;
    addr_trace = 3'd1;
    clr_err    = 1'b0;
    cyc++;
    sb.delete();
    g1 = 1'b0; g2 = 1'b0;
    exp_data_fill = 3'b000; exp_data_trace = 3'b000;
    exp_oob = 1'b0; last_trace = 1'b0;
    @(negedge clk);
    checkOutput("rst_gnt_fill",    8'(gnt_fill),    8'h00);
    checkOutput("rst_gnt_trace",   8'(gnt_trace),   8'h00);
    checkOutput("rst_ram_en",      8'(ram_en),      8'h00);
    checkOutput("rst_ram_addr",    8'(ram_addr),    8'h00);
    checkOutput("rst_valid_fill",  8'(valid_fill),  8'h00);
    checkOutput("rst_valid_trace", 8'(valid_trace), 8'h00);
    checkOutput("rst_data_fill",   8'(data_fill),   8'h00);
    checkOutput("rst_data_trace",  8'(data_trace),  8'h00);
    checkOutput("rst_oob_err",     8'(oob_err),     8'h00);
    checkOutput("rst_busy",        8'(busy),        8'h00);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 3'b000;
    mem[0] = 3'b110; mem[1] = 3'b100; mem[2] = 3'b110; mem[3] = 3'b011; mem[4] = 3'b001;

    doReset();
    runCycle(0, 0, 0, 0, 0);

    // Single fill read of address 3, then watch the data hold.
    runCycle(1, 3, 0, 0, 0);
    for (int i = 0; i < 4; i++) runCycle(0, 0, 0, 0, 0);

    // Back-to-back fill reads of addresses 0..4.
    for (int a = 0; a < 5; a++) runCycle(1, 3'(a), 0, 0, 0);
    for (int i = 0; i < 3; i++) runCycle(0, 0, 0, 0, 0);

    // Both requesters asking every cycle.
    for (int i = 0; i < 5; i++) runCycle(1, 1, 1, 4, 0);
    for (int i = 0; i < 3; i++) runCycle(0, 0, 0, 0, 0);

    // Out-of-range traceback read, sticky error, clear, then clear racing a new set.
    runCycle(0, 0, 1, 5, 0);
    for (int i = 0; i < 3; i++) runCycle(0, 0, 0, 0, 0);
    runCycle(0, 0, 0, 0, 1);
    runCycle(0, 0, 0, 0, 0);
    runCycle(0, 0, 1, 6, 1);
    runCycle(0, 0, 0, 0, 0);
    runCycle(0, 0, 0, 0, 1);
    for (int i = 0; i < 2; i++) runCycle(0, 0, 0, 0, 0);

    // Reset during the cycle after a grant: that read must vanish.
    runCycle(1, 2, 0, 0, 0);
    doReset();
    for (int i = 0; i < 4; i++) runCycle(0, 0, 0, 0, 0);
    runCycle(0, 0, 1, 4, 0);
    for (int i = 0; i < 3; i++) runCycle(0, 0, 0, 0, 0);

    checkOutput("scoreboard_empty", 8'(sb.size()), 8'h00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
